fre_gate_ctrl: RTL and testbench

// - Measurement sequencer for the frequency-counter datapath: opens a counting gate of precise length, then drives the

---
 rtl/fre_gate_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_fre_gate_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fre_gate_ctrl.sv
// ---------------------------------------------------------------------------
// fre_gate_ctrl
// Measurement sequencer for the frequency-counter datapath. It opens a
// counting gate of a precise length (selected by the current range), waits for
// the counter's input synchroniser to drain, latches the count and reports the
// range and overflow status that belong to the latched result.
//
// Build option:
//   FRE_AUTORANGE_EN  defined   -> range steps automatically after each result
//                                  (down on overflow, up on an empty top digit)
//                     undefined -> range comes from range_sel (3 acts as 2),
//                                  sampled at the start of every measurement
//
// Ports:
//   clk100        in   system clock
//   rst           in   asynchronous active-high reset
//   en            in   continuous mode, re-arm after the hold period
//   start         in   single-cycle request to measure once from idle
//   range_sel     in   manual range 0..2 (3 behaves as 2)
//   cnt_ovf       in   counter overflow flag
//   cnt_top_zero  in   counter's most significant digit is zero
//   cnt_clr       out  one-cycle counter clear
//   cnt_en        out  counting gate
//   cnt_latch     out  one-cycle copy of the count to the display registers
//   range_o       out  range the displayed result was gated with
//   ovf_o         out  displayed result overflowed
//   meas_valid    out  one-cycle pulse after a new result was latched
//   busy          out  high whenever a measurement sequence is in progress
// ---------------------------------------------------------------------------
module fre_gate_ctrl #(
    parameter int GATE_BASE  = 1_000_000,
    parameter int SETTLE_CYC = 4,
    parameter int HOLD_CYC   = 1_000_000
) (
    input  logic       clk100,
    input  logic       rst,
    input  logic       en,
    input  logic       start,
    input  logic [1:0] range_sel,
    input  logic       cnt_ovf,
    input  logic       cnt_top_zero,
    output logic       cnt_clr,
    output logic       cnt_en,
    output logic       cnt_latch,
    output logic [1:0] range_o,
    output logic       ovf_o,
    output logic       meas_valid,
    output logic       busy
);

    localparam int GATE_W  = $clog2(GATE_BASE * 100);
    localparam int AUX_MAX = (SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC;
    localparam int AUX_W   = (AUX_MAX > 1) ? $clog2(AUX_MAX) : 1;

    localparam logic [GATE_W-1:0] GATE_LAST0  = GATE_W'(GATE_BASE - 1);
    localparam logic [GATE_W-1:0] GATE_LAST1  = GATE_W'(GATE_BASE * 10 - 1);
    localparam logic [GATE_W-1:0] GATE_LAST2  = GATE_W'(GATE_BASE * 100 - 1);
    localparam logic [AUX_W-1:0]  SETTLE_LAST = AUX_W'(SETTLE_CYC - 1);
    localparam logic [AUX_W-1:0]  HOLD_LAST   = AUX_W'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GATE,
        SETTLE,
        LATCH,
        EVAL,
        HOLD
    } state_t;

    state_t            state;
    logic [1:0]        cur_rng;
    logic [GATE_W-1:0] gate_cnt;
    logic [AUX_W-1:0]  aux_cnt;
    logic [GATE_W-1:0] gate_last;

`ifdef FRE_AUTORANGE_EN
    logic unused_range_sel;
    assign unused_range_sel = ^range_sel;
`else
    logic unused_top_zero;
    assign unused_top_zero = cnt_top_zero;
`endif

    // The gate counter runs from zero up to the last cycle of the gate, so
    // the terminal value is one less than the gate length for the range.
    always_comb begin
        gate_last = GATE_LAST2;
        case (cur_rng)
            2'd0:    gate_last = GATE_LAST0;
            2'd1:    gate_last = GATE_LAST1;
            default: gate_last = GATE_LAST2;
        endcase
    end

    // Sequencer. All outputs are registered: each output is set on the edge
    // that enters the state it belongs to, so the strobes are glitch-free and
    // line up exactly with the state. The one-cycle strobes default low every
    // cycle and are raised only on the entering transition. aux_cnt is shared
    // between the settle and hold waits since they never overlap.
    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cur_rng    <= 2'd0;
            gate_cnt   <= '0;
            aux_cnt    <= '0;
            cnt_clr    <= 1'b0;
            cnt_en     <= 1'b0;
            cnt_latch  <= 1'b0;
            range_o    <= 2'd0;
            ovf_o      <= 1'b0;
            meas_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            cnt_clr    <= 1'b0;
            cnt_latch  <= 1'b0;
            meas_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start || en) begin
                        state   <= CLEAR;
                        cnt_clr <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                CLEAR: begin
`ifndef FRE_AUTORANGE_EN
                    cur_rng  <= (range_sel == 2'd3) ? 2'd2 : range_sel;
`endif
                    state    <= GATE;
                    cnt_en   <= 1'b1;
                    gate_cnt <= '0;
                end
                GATE: begin
                    if (gate_cnt == gate_last) begin
                        state   <= SETTLE;
                        cnt_en  <= 1'b0;
                        aux_cnt <= '0;
                    end else begin
                        gate_cnt <= gate_cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (aux_cnt == SETTLE_LAST) begin
                        state     <= LATCH;
                        cnt_latch <= 1'b1;
                        range_o   <= cur_rng;
                        ovf_o     <= cnt_ovf;
                    end else begin
                        aux_cnt <= aux_cnt + 1'b1;
                    end
                end
                LATCH: begin
                    state      <= EVAL;
                    meas_valid <= 1'b1;
                end
                EVAL: begin
`ifdef FRE_AUTORANGE_EN
                    if (cnt_ovf && (cur_rng != 2'd0)) begin
                        cur_rng <= cur_rng - 2'd1;
                    end else if (cnt_top_zero && (cur_rng < 2'd2)) begin
                        cur_rng <= cur_rng + 2'd1;
                    end
`endif
                    state   <= HOLD;
                    aux_cnt <= '0;
                end
                HOLD: begin
                    if (aux_cnt == HOLD_LAST) begin
                        if (en) begin
                            state   <= CLEAR;
                            cnt_clr <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        aux_cnt <= aux_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt_en <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fre_gate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fre_gate_ctrl
// Self-checking bench for fre_gate_ctrl with short gate, settle and hold
// lengths. A small behavioural model tracks the range that each measurement
// should use (range_sel in the manual build, the step-up/step-down rules in
// the auto-range build) and derives gate length, settle delay, hold length
// and reported range/overflow from that range with plain arithmetic. Each
// measurement is walked cycle by cycle on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_fre_gate_ctrl;

    localparam int GATE_BASE  = 10;
    localparam int SETTLE_CYC = 2;
    localparam int HOLD_CYC   = 4;

    logic       clk100 = 1'b0;
    logic       rst;
    logic       en;
    logic       start;
    logic [1:0] range_sel;
    logic       cnt_ovf;
    logic       cnt_top_zero;
    logic       cnt_clr;
    logic       cnt_en;
    logic       cnt_latch;
    logic [1:0] range_o;
    logic       ovf_o;
    logic       meas_valid;
    logic       busy;

    logic start_main;
    logic noise_start;
    logic noise_on;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_clr = 0;
    int prev_clr = 0;
    int model_rng = 0;

    assign start = start_main | noise_start;

    fre_gate_ctrl #(
        .GATE_BASE (GATE_BASE),
        .SETTLE_CYC(SETTLE_CYC),
        .HOLD_CYC  (HOLD_CYC)
    ) dut (
        .clk100      (clk100),
        .rst         (rst),
        .en          (en),
        .start       (start),
        .range_sel   (range_sel),
        .cnt_ovf     (cnt_ovf),
        .cnt_top_zero(cnt_top_zero),
        .cnt_clr     (cnt_clr),
        .cnt_en      (cnt_en),
        .cnt_latch   (cnt_latch),
        .range_o     (range_o),
        .ovf_o       (ovf_o),
        .meas_valid  (meas_valid),
        .busy        (busy)
    );

    // 100 MHz clock.
    always #5 clk100 = ~clk100;

    // Free-running cycle count used to time the distance between clears.
    always @(posedge clk100) cyc <= cyc + 1;

    // While enabled, throws random start pulses at the design while it is
    // busy; these must never cause an extra measurement.
    initial begin
        noise_start = 1'b0;
        forever begin
            @(negedge clk100);
            noise_start = noise_on && (busy === 1'b1) && ($urandom_range(0, 3) == 0);
        end
    end

    // Hard stop in case the design wedges somewhere no bounded wait covers.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int gateLen(input int r);
        int g;
        g = GATE_BASE;
        for (int i = 0; i < r; i++) g = g * 10;
        return g;
    endfunction

    function automatic int expRange();
`ifdef FRE_AUTORANGE_EN
        return model_rng;
`else
        return (range_sel == 2'd3) ? 2 : int'(range_sel);
`endif
    endfunction

    function automatic void modelUpdate();
`ifdef FRE_AUTORANGE_EN
        if (cnt_ovf && model_rng > 0) model_rng = model_rng - 1;
        else if (cnt_top_zero && model_rng < 2) model_rng = model_rng + 1;
`endif
    endfunction

    function automatic int periodFor(input int r);
        return 1 + gateLen(r) + SETTLE_CYC + 1 + 1 + HOLD_CYC;
    endfunction

    // Walks one full measurement. Called at a falling edge with the trigger
    // already applied (or with the design already in CLEAR when repeating).
    // Returns at the falling edge after the last hold cycle.
    task automatic applyStimulus(input logic drop_en, output int used_rng);
        int n;
        int r;
        n = 0;
        while (cnt_clr !== 1'b1 && n < 50) begin
            @(negedge clk100);
            n++;
        end
        start_main = 1'b0;
        checkOutput("clr_seen", cnt_clr, 1);
        checkOutput("busy_in_clear", busy, 1);
        prev_clr = last_clr;
        last_clr = cyc;
        r = expRange();
        used_rng = r;

        @(negedge clk100);
        checkOutput("clr_width", cnt_clr, 0);
        checkOutput("gate_open", cnt_en, 1);

        n = 0;
        while (cnt_en === 1'b1 && n < 5000) begin
            n++;
            if (drop_en && n == 3) en = 1'b0;
            @(negedge clk100);
        end
        checkOutput("gate_len", n, gateLen(r));

        n = 0;
        while (cnt_latch !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk100);
        end
        checkOutput("settle_len", n, SETTLE_CYC);

        @(negedge clk100);
        checkOutput("meas_valid", meas_valid, 1);
        checkOutput("latch_width", cnt_latch, 0);
        checkOutput("range_o", range_o, r);
        checkOutput("ovf_o", ovf_o, cnt_ovf);
        modelUpdate();

        n = 0;
        @(negedge clk100);
        while (busy === 1'b1 && cnt_clr !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk100);
        end
        checkOutput("hold_len", n, HOLD_CYC);
        checkOutput("repeat_clr", cnt_clr, en);
        checkOutput("busy_after_hold", busy, en);
        checkOutput("range_held", range_o, r);
        checkOutput("valid_width", meas_valid, 0);
    endtask

    task automatic checkResetOutputs(input string phase);
        checkOutput({phase, "_cnt_clr"}, cnt_clr, 0);
        checkOutput({phase, "_cnt_en"}, cnt_en, 0);
        checkOutput({phase, "_cnt_latch"}, cnt_latch, 0);
        checkOutput({phase, "_range_o"}, range_o, 0);
        checkOutput({phase, "_ovf_o"}, ovf_o, 0);
        checkOutput({phase, "_meas_valid"}, meas_valid, 0);
        checkOutput({phase, "_busy"}, busy, 0);
    endtask

    initial begin
        int r;
        int n;
        int clr_seen;
        int auto_seq [4];

        rst          = 1'b1;
        en           = 1'b0;
        start_main   = 1'b0;
        noise_on     = 1'b0;
        range_sel    = 2'd0;
        cnt_ovf      = 1'b0;
        cnt_top_zero = 1'b0;
        model_rng    = 0;

        repeat (3) @(negedge clk100);
        checkResetOutputs("rst");
        rst = 1'b0;
        repeat (3) @(negedge clk100);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_clr", cnt_clr, 0);

        $display("[TB] single measurement, range_sel=1");
        range_sel  = 2'd1;
        start_main = 1'b1;
        applyStimulus(1'b0, r);

        $display("[TB] continuous mode with start noise");
        range_sel = 2'd0;
        en        = 1'b1;
        noise_on  = 1'b1;
        applyStimulus(1'b0, r);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, r);
            checkOutput("clr_period", last_clr - prev_clr, periodFor(r));
        end
        noise_on = 1'b0;
        applyStimulus(1'b1, r);
        checkOutput("clr_period_last", last_clr - prev_clr, periodFor(r));
        clr_seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk100);
            if (cnt_clr === 1'b1) clr_seen++;
        end
        checkOutput("no_clr_after_en_drop", clr_seen, 0);
        checkOutput("idle_after_en_drop", busy, 0);

        $display("[TB] randomized single measurements");
        for (int i = 0; i < 8; i++) begin
            range_sel    = 2'($urandom_range(0, 3));
            cnt_ovf      = 1'($urandom_range(0, 1));
            cnt_top_zero = 1'($urandom_range(0, 1));
            start_main   = 1'b1;
            applyStimulus(1'b0, r);
        end

        $display("[TB] reset in the middle of a gate");
        range_sel    = 2'd2;
        cnt_ovf      = 1'b1;
        cnt_top_zero = 1'b0;
        start_main   = 1'b1;
        applyStimulus(1'b0, r);
        cnt_ovf    = 1'b0;
        start_main = 1'b1;
        n = 0;
        while (cnt_en !== 1'b1 && n < 50) begin
            @(negedge clk100);
            n++;
        end
        start_main = 1'b0;
        checkOutput("gate_reached", cnt_en, 1);
        repeat (5) @(negedge clk100);
        rst = 1'b1;
        #1;
        checkResetOutputs("midrst");
        model_rng = 0;
        @(negedge clk100);
        rst = 1'b0;
        repeat (2) @(negedge clk100);
        checkOutput("post_rst_busy", busy, 0);
        range_sel  = 2'd0;
        start_main = 1'b1;
        applyStimulus(1'b0, r);

`ifdef FRE_AUTORANGE_EN
        $display("[TB] auto-range stepping");
        rst = 1'b1;
        @(negedge clk100);
        rst = 1'b0;
        model_rng    = 0;
        auto_seq     = '{0, 1, 2, 2};
        cnt_ovf      = 1'b0;
        cnt_top_zero = 1'b1;
        en           = 1'b1;
        @(negedge clk100);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, r);
            checkOutput("auto_seq_range", range_o, auto_seq[i]);
        end
        cnt_ovf = 1'b1;
        applyStimulus(1'b0, r);
        checkOutput("auto_ovf_range", range_o, 2);
        checkOutput("auto_ovf_flag", ovf_o, 1);
        applyStimulus(1'b1, r);
        checkOutput("auto_after_ovf_range", range_o, 1);
        repeat (5) @(negedge clk100);
        checkOutput("auto_idle", busy, 0);
`else
        auto_seq = '{0, 0, 0, 0};
        checkOutput("manual_seq_unused", auto_seq[0] + int'(busy), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
